window_3x3: RTL and testbench
=============================

WINDOW_3X3 -- requirements
Module: window_3x3

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 8, meaning pixel word width in bits.
REQ-002 The block SHALL have parameter IMAGE_WIDTH, default 640, meaning pixels per line (legal range 3..4096).
REQ-003 The block SHALL have parameter IMAGE_HEIGHT, default 480, meaning lines per frame (legal range 3..4096).
REQ-004 The block SHALL have port clock  input  1  rising-edge system clock.
REQ-005 The block SHALL have port n_rst  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port in_valid  input  1  in_data holds a raster-order pixel this cycle.
REQ-007 The block SHALL have port in_frame_start  input  1  qualified by in_valid; the pixel is (0,0) of a new frame.
REQ-008 The block SHALL have port in_data  input  BIT_WIDTH  pixel value.
REQ-009 The block SHALL have port out_valid  output  1  out_window, out_x and out_y hold a complete window this cycle.
REQ-010 The block SHALL have port out_window  output  9*BIT_WIDTH  3x3 neighbourhood; element (r,c) at bits [BIT_WIDTH*(3*r+c) +: BIT_WIDTH], r=0 top, c=0 left.
REQ-011 The block SHALL have port out_x  output  $clog2(IMAGE_WIDTH)  column of the window centre.
REQ-012 The block SHALL have port out_y  output  $clog2(IMAGE_HEIGHT)  row of the window centre.

Function
REQ-013 The block SHALL track input position with counters x (0..IMAGE_WIDTH-1) and y (0..IMAGE_HEIGHT-1) that advance only on cycles with in_valid=1.
REQ-014 x SHALL wrap to 0 after IMAGE_WIDTH-1 and increment y; y SHALL wrap to 0 after (IMAGE_WIDTH-1, IMAGE_HEIGHT-1).
REQ-015 in_valid=1 with in_frame_start=1 SHALL treat the pixel as (0,0) regardless of counter state, discarding any partial frame; in_frame_start with in_valid=0 SHALL be ignored.
REQ-016 Two line delays SHALL be built from fifo_sc instances (FIFO_SIZE=IMAGE_WIDTH) with wr_en=rd_en=in_valid, so each yields the pixel exactly one line earlier in valid-pixel count, independent of in_valid gaps.
REQ-017 Each row of the window SHALL be held in a 3-deep shift register advancing only on in_valid=1.
REQ-018 On a cycle where in_valid=1 delivers pixel (x,y) with x>=2 and y>=2, the next cycle SHALL have out_valid=1, out_window = pixels (x-2..x, y-2..y), out_x=x-1, out_y=y-1 (latency exactly 1 clock).
REQ-019 out_valid SHALL be 0 in every other cycle, including all in_valid=0 cycles and pixels with x<2 or y<2; no border/padded windows are produced.
REQ-020 Outputs SHALL hold their last values while out_valid=0; consumers SHALL ignore them.
REQ-021 Windows SHALL never mix pixels from different lines horizontally or from different frames vertically; the first two lines after reset or in_frame_start SHALL produce no windows.
REQ-022 The block SHALL have no backpressure; it accepts one pixel per cycle indefinitely, and each frame yields exactly (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) windows.

Reset
REQ-023 While n_rst=0 at a rising edge, x, y, out_valid, out_window, out_x and out_y SHALL become 0, and the line-delay fifo_sc instances SHALL be reset.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release, pixels SHALL be counted from (0,0) whether or not in_frame_start is asserted.
REQ-025 No out_valid=1 SHALL appear earlier than the third line after reset release.

Verification
REQ-026 Continuous frame, IMAGE_WIDTH=5, IMAGE_HEIGHT=4, pixel value 10*y+x -> 6 windows; the first, one cycle after pixel (2,2), has out_x=1, out_y=1, out_window rows {0,1,2},{10,11,12},{20,21,22}.
REQ-027 Same frame with in_valid deasserted on a random 50% of cycles -> identical window sequence and values, each window 1 cycle after its enabling pixel.
REQ-028 Two back-to-back frames, second with different data -> 6 windows per frame; the first window of frame 2 contains only frame-2 pixels.
REQ-029 in_frame_start asserted at pixel (3,2) of frame 1 -> that pixel becomes (0,0); no window until new (2,2); subsequent values are correct.
REQ-030 n_rst pulsed low for 1 cycle mid-line 2 -> all outputs 0 the next cycle; the following 5x4 frame produces exactly 6 correct windows.
REQ-031 Line wrap check -> pixels (0,y) and (1,y) never produce out_valid; window for pixel (4,3) has out_x=3, out_y=2, bottom row {32,33,34}.

Source files
------------

// File: rtl/window_3x3.sv
// 3x3 sliding-window generator for raster-order pixel streams.
// Two line delays feed three row shift registers; a window is emitted one clock after each interior pixel.

module fifo_sc #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 16
) (
  input  logic                  clock,
  input  logic                  n_rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int AW = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_SIZE - 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  // Read is combinational so a same-cycle write/read returns the entry
  // written FIFO_SIZE accepted words ago.
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
    end
  end
endmodule

module window_3x3 #(
  parameter int BIT_WIDTH    = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic                            clock,
  input  logic                            n_rst,
  input  logic                            in_valid,
  input  logic                            in_frame_start,
  input  logic [BIT_WIDTH-1:0]            in_data,
  output logic                            out_valid,
  output logic [9*BIT_WIDTH-1:0]          out_window,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  out_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] out_y
);
  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          win_hit;

  logic [BIT_WIDTH-1:0] line1;
  logic [BIT_WIDTH-1:0] line2;

  // [row][col][bits]; col 0 is the oldest (leftmost) pixel, row 0 the top line.
  logic [2:0][2:0][BIT_WIDTH-1:0] row_sr;
  logic [2:0][2:0][BIT_WIDTH-1:0] row_next;
  logic [2:0][BIT_WIDTH-1:0]      row_in;

  // Frame start forces the current pixel to (0,0) whatever the counters say.
  assign cur_x   = in_frame_start ? '0 : x_cnt;
  assign cur_y   = in_frame_start ? '0 : y_cnt;
  assign win_hit = in_valid && (cur_x >= XW'(2)) && (cur_y >= YW'(2));

  fifo_sc #(
    .DATA_WIDTH(BIT_WIDTH),
    .FIFO_SIZE (IMAGE_WIDTH)
  ) u_line_dly1 (
    .clock  (clock),
    .n_rst  (n_rst),
    .wr_en  (in_valid),
    .wr_data(in_data),
    .rd_en  (in_valid),
    .rd_data(line1)
  );

  fifo_sc #(
    .DATA_WIDTH(BIT_WIDTH),
    .FIFO_SIZE (IMAGE_WIDTH)
  ) u_line_dly2 (
    .clock  (clock),
    .n_rst  (n_rst),
    .wr_en  (in_valid),
    .wr_data(line1),
    .rd_en  (in_valid),
    .rd_data(line2)
  );

  always_comb begin
    row_in[0] = line2;
    row_in[1] = line1;
    row_in[2] = in_data;
    row_next  = row_sr;
    for (int r = 0; r < 3; r++) begin
      row_next[r] = {row_in[r], row_sr[r][2], row_sr[r][1]};
    end
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      row_sr     <= '0;
      out_valid  <= 1'b0;
      out_window <= '0;
      out_x      <= '0;
      out_y      <= '0;
    end else begin
      out_valid <= win_hit;
      if (in_valid) begin
        row_sr <= row_next;
        if (cur_x == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
        end else begin
          x_cnt <= cur_x + 1'b1;
          y_cnt <= cur_y;
        end
      end
      // Window registers load only on hits so they hold between windows.
      if (win_hit) begin
        out_window <= row_next;
        out_x      <= cur_x - XW'(1);
        out_y      <= cur_y - YW'(1);
      end
    end
  end
endmodule

// File: tb/tb_window_3x3.sv
// Directed bench for window_3x3 on a 5x4 image: continuous, gapped, back-to-back,
// mid-frame restart and mid-line reset scenarios, checked against pixel = base + 10*y + x.

module tb_window_3x3;
  localparam int BW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic            clock = 1'b0;
  logic            n_rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_frame_start = 1'b0;
  logic [BW-1:0]   in_data = '0;
  logic            out_valid;
  logic [9*BW-1:0] out_window;
  logic [2:0]      out_x;
  logic [1:0]      out_y;

  int              n_checks = 0;
  int              n_fail = 0;
  int              win_count;
  logic [71:0]     last_win;
  logic [71:0]     first_obs;
  logic [71:0]     last_obs;

  window_3x3 #(
    .BIT_WIDTH   (BW),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clock         (clock),
    .n_rst         (n_rst),
    .in_valid      (in_valid),
    .in_frame_start(in_frame_start),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_window    (out_window),
    .out_x         (out_x),
    .out_y         (out_y)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int base, input int x, input int y);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[BW*(3*r+c) +: BW] = 8'(base + 10*(y-2+r) + (x-2+c));
    return w;
  endfunction

  task automatic cycle(input logic v, input logic fs, input logic [BW-1:0] d);
    in_valid       = v;
    in_frame_start = fs;
    in_data        = d;
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  72'(out_valid),  72'd0);
    check({tag, "_window"}, out_window,      72'd0);
    check({tag, "_x"},      72'(out_x),      72'd0);
    check({tag, "_y"},      72'(out_y),      72'd0);
  endtask

  // Idle cycles sometimes carry a stray frame-start, which must be ignored.
  task automatic idle_cycle();
    cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    check("idle_valid", 72'(out_valid), 72'd0);
    check("idle_hold",  out_window,     last_win);
  endtask

  task automatic send_frame(input int base, input int npix, input bit use_fs, input bit gaps);
    int x;
    int y;
    logic [71:0] ew;
    win_count = 0;
    for (int i = 0; i < npix; i++) begin
      x = i % W;
      y = i / W;
      if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
      cycle(1'b1, use_fs && (i == 0), 8'(base + 10*y + x));
      if (x >= 2 && y >= 2) begin
        ew = exp_win(base, x, y);
        check("win_valid", 72'(out_valid), 72'd1);
        check("win_data",  out_window,     ew);
        check("win_x",     72'(out_x),     72'(x - 1));
        check("win_y",     72'(out_y),     72'(y - 1));
        last_win = ew;
        last_obs = out_window;
        win_count++;
        if (win_count == 1) first_obs = out_window;
      end else begin
        check("border_valid", 72'(out_valid), 72'd0);
      end
    end
    in_valid       = 1'b0;
    in_frame_start = 1'b0;
  endtask

  initial begin
    last_win = '0;
    n_rst = 1'b0;
    cycle(1'b0, 1'b0, 8'd0);
    cycle(1'b1, 1'b1, 8'd99);
    check_zero("reset");
    n_rst = 1'b1;

    // Continuous frame
    send_frame(0, W*H, 1'b1, 1'b0);
    check("frame1_count", 72'(win_count), 72'd6);
    check("frame1_first", first_obs, 72'h16_15_14_0C_0B_0A_02_01_00);
    check("frame1_bottom_row", 72'(last_obs[71:48]), 72'h22_21_20);
    idle_cycle();

    // Same frame with random input gaps
    send_frame(0, W*H, 1'b1, 1'b1);
    check("gaps_count", 72'(win_count), 72'd6);

    // Back-to-back frames with different data
    send_frame(100, W*H, 1'b1, 1'b0);
    check("b2b_f1_count", 72'(win_count), 72'd6);
    send_frame(50, W*H, 1'b1, 1'b0);
    check("b2b_f2_count", 72'(win_count), 72'd6);
    check("b2b_f2_first", first_obs, 72'h48_47_46_3E_3D_3C_34_33_32);

    // Frame start at pixel (3,2) of a partial frame
    send_frame(0, 13, 1'b1, 1'b0);
    check("partial_count", 72'(win_count), 72'd1);
    send_frame(200, W*H, 1'b1, 1'b0);
    check("restart_count", 72'(win_count), 72'd6);

    // Reset pulse mid-line 2, then a frame without frame-start
    send_frame(0, 12, 1'b1, 1'b0);
    check("pre_reset_count", 72'(win_count), 72'd0);
    n_rst = 1'b0;
    cycle(1'b1, 1'b0, 8'd77);
    n_rst = 1'b1;
    check_zero("mid_reset");
    last_win = '0;
    idle_cycle();
    send_frame(30, W*H, 1'b0, 1'b1);
    check("post_reset_count", 72'(win_count), 72'd6);
    check("post_reset_bottom_row", 72'(last_obs[71:48]), 72'h40_3F_3E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
